// File: rtl/rv_pkg.sv
// Shared defaults and types for the integer register file slice.
package rv_pkg;

    localparam int DEF_XLEN     = 32;
    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_AW       = $clog2(DEF_NUM_REGS);
    localparam int REG_ZERO     = 0;

    typedef logic [DEF_AW-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// Busy-bit scoreboard: one outstanding-producer flag per architectural register.
module regfile_scoreboard
    import rv_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int AW       = $clog2(NUM_REGS),
    parameter int BYPASS   = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] rs1,
    input  logic [AW-1:0] rs2,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic          iss_valid,
    input  logic [AW-1:0] iss_rd,
    input  logic          flush,
    output logic          rs1_busy,
    output logic          rs2_busy
);

    // x0 has no storage; index 0 of the query vector is tied low.
    logic [NUM_REGS-1:1] busy;
    logic [NUM_REGS-1:0] busy_vec;
    logic                wr_live;
    logic                iss_live;

    assign busy_vec = {busy, 1'b0};
    assign wr_live  = we && (wa != AW'(REG_ZERO));
    assign iss_live = iss_valid && (iss_rd != AW'(REG_ZERO));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else if (flush) begin
            busy <= '0;
        end else begin
            for (int unsigned i = 1; i < NUM_REGS; i++) begin
                if (iss_live && (iss_rd == AW'(i)))
                    busy[i] <= 1'b1;
                else if (wr_live && (wa == AW'(i)))
                    busy[i] <= 1'b0;
            end
        end
    end

    always_comb begin
        rs1_busy = busy_vec[rs1];
        rs2_busy = busy_vec[rs2];
        if (BYPASS != 0) begin
            if (wr_live && (wa == rs1)) rs1_busy = 1'b0;
            if (wr_live && (wa == rs2)) rs2_busy = 1'b0;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Integer register file with two combinational read ports, one write port and a busy scoreboard.
module regfile_sb
    import rv_pkg::*;
#(
    parameter int XLEN     = DEF_XLEN,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int AW       = $clog2(NUM_REGS),
    parameter int BYPASS   = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            we,
    input  logic [AW-1:0]   wa,
    input  logic [XLEN-1:0] wd,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rd,
    input  logic            flush
);

    logic [XLEN-1:0] mem [NUM_REGS];
    logic            wr_live;

    assign wr_live = we && (wa != AW'(REG_ZERO));

    // mem[0] is reset and never written, so it always reads as zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++)
                mem[i] <= '0;
        end else if (wr_live) begin
            mem[wa] <= wd;
        end
    end

    always_comb begin
        rd1 = mem[rs1];
        rd2 = mem[rs2];
        if (BYPASS != 0) begin
            if (wr_live && (wa == rs1)) rd1 = wd;
            if (wr_live && (wa == rs2)) rd2 = wd;
        end
        if (rs1 == AW'(REG_ZERO)) rd1 = '0;
        if (rs2 == AW'(REG_ZERO)) rd2 = '0;
    end

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .AW       (AW),
        .BYPASS   (BYPASS)
    ) u_sb (
        .clk       (clk),
        .rst       (rst),
        .rs1       (rs1),
        .rs2       (rs2),
        .we        (we),
        .wa        (wa),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .flush     (flush),
        .rs1_busy  (rs1_busy),
        .rs2_busy  (rs2_busy)
    );

endmodule
